// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder constants and prefix FSM state type.
// Pure declarations: no timing and no flow control of its own.
// Used by ps2_scan_decoder.
package ps2_pkg;

  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_BRK    = 8'hF0;
  localparam logic [7:0] CODE_BAT    = 8'hAA;
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_RESEND = 8'hFE;
  localparam logic [7:0] CODE_ERR0   = 8'h00;
  localparam logic [7:0] CODE_ERR1   = 8'hFF;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_state_t;

  // Keyboard status/handshake bytes that never form part of a key sequence.
  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == CODE_BAT) || (b == CODE_ACK) || (b == CODE_RESEND) ||
           (b == CODE_ERR0) || (b == CODE_ERR1);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Scan-code set 2 to ASCII for letters, digits, space, enter and backspace.
// Latency: combinational, no registers.
// Backpressure: none; pure lookup.
module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] base;
  logic [7:0] alt;
  logic       is_letter;
  logic       is_digit;

  always_comb begin
    base = 8'h00;
    alt  = 8'h00;
    case (code)
      8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
      8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
      8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
      8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
      8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
      8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
      8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
      8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
      // Digit row: alt holds the shifted symbol.
      8'h45: begin base = 8'h30; alt = 8'h29; end
      8'h16: begin base = 8'h31; alt = 8'h21; end
      8'h1E: begin base = 8'h32; alt = 8'h40; end
      8'h26: begin base = 8'h33; alt = 8'h23; end
      8'h25: begin base = 8'h34; alt = 8'h24; end
      8'h2E: begin base = 8'h35; alt = 8'h25; end
      8'h36: begin base = 8'h36; alt = 8'h5E; end
      8'h3D: begin base = 8'h37; alt = 8'h26; end
      8'h3E: begin base = 8'h38; alt = 8'h2A; end
      8'h46: begin base = 8'h39; alt = 8'h28; end
      8'h29: base = 8'h20;
      8'h5A: base = 8'h0D;
      8'h66: base = 8'h08;
      default: base = 8'h00;
    endcase
    is_letter = (base >= 8'h61) && (base <= 8'h7A);
    is_digit  = (alt != 8'h00);
    if (ext)
      ascii = 8'h00;
    else if (is_letter && (shift ^ caps))
      ascii = base & 8'hDF;
    else if (is_digit && shift)
      ascii = alt;
    else
      ascii = base;
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan bytes to key events with Shift/CapsLock (CapsLock under PS2_DEC_CAPSLOCK_EN).
// Latency: 1 clock from final byte to ev_valid and modifier update.
// Backpressure: single-entry output register; new events drop with an overrun pulse when full.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int BREAK_OUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] ev_ascii,
  output logic       shift_o,
  output logic       caps_o,
  output logic       overrun
);

  ps2_state_t state_q, state_d;
  logic       seq_done;
  logic       cur_ext;
  logic       cur_brk;
  logic       ev_gen;
  logic       can_load;
  logic       lshift, rshift;
  logic       caps_lut;
  logic [7:0] ascii_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    seq_done = 1'b0;
    if (byte_vld) begin
      if (byte_in == CODE_EXT) begin
        state_d = EXT;
      end else if (byte_in == CODE_BRK) begin
        case (state_q)
          IDLE:    state_d = BRK;
          EXT:     state_d = EXT_BRK;
          default: state_d = state_q;
        endcase
      end else if (is_ctrl(byte_in)) begin
        state_d = IDLE;
      end else begin
        state_d  = IDLE;
        seq_done = 1'b1;
      end
    end
    cur_ext  = (state_q == EXT) || (state_q == EXT_BRK);
    cur_brk  = (state_q == BRK) || (state_q == EXT_BRK);
    ev_gen   = seq_done && (!cur_brk || (BREAK_OUT != 0));
    can_load = !ev_valid || ev_ready;
  end

  assign caps_lut = caps_o;

  // Lookup sees the registered modifiers, i.e. the state before this byte.
  ps2_ascii_lut u_lut (
    .code  (byte_in),
    .ext   (cur_ext),
    .shift (shift_o),
    .caps  (caps_lut),
    .ascii (ascii_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_code  <= 8'h00;
      ev_ext   <= 1'b0;
      ev_break <= 1'b0;
      ev_ascii <= 8'h00;
      overrun  <= 1'b0;
      lshift   <= 1'b0;
      rshift   <= 1'b0;
    end else begin
      overrun <= ev_gen && !can_load;
      if (ev_gen && can_load) begin
        ev_valid <= 1'b1;
        ev_code  <= byte_in;
        ev_ext   <= cur_ext;
        ev_break <= cur_brk;
        ev_ascii <= ascii_nxt;
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end
      if (seq_done && !cur_ext) begin
        if (byte_in == CODE_LSHIFT) lshift <= !cur_brk;
        if (byte_in == CODE_RSHIFT) rshift <= !cur_brk;
      end
    end
  end

  assign shift_o = lshift | rshift;

`ifdef PS2_DEC_CAPSLOCK_EN
  logic caps_held;

  // caps_held masks typematic repeats so a held key toggles only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      caps_o    <= 1'b0;
      caps_held <= 1'b0;
    end else if (seq_done && !cur_ext && (byte_in == CODE_CAPS)) begin
      if (cur_brk) begin
        caps_held <= 1'b0;
      end else begin
        caps_held <= 1'b1;
        if (!caps_held) caps_o <= !caps_o;
      end
    end
  end
`else
  assign caps_o = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Randomized and directed bench for ps2_scan_decoder, BREAK_OUT=0 and =1 side by side.
// Expected events come from a sequence-level reference model held in the bench.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_vld;
  logic       ev_ready;
  logic       ev_valid [2];
  logic       ev_ext   [2];
  logic       ev_break [2];
  logic       shift_o  [2];
  logic       caps_o   [2];
  logic       overrun  [2];
  logic [7:0] ev_code  [2];
  logic [7:0] ev_ascii [2];

  int n_pass = 0;
  int n_chk  = 0;

  ps2_scan_decoder #(.BREAK_OUT(0)) u_dec0 (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_vld(byte_vld),
    .ev_valid(ev_valid[0]), .ev_ready(ev_ready), .ev_code(ev_code[0]),
    .ev_ext(ev_ext[0]), .ev_break(ev_break[0]), .ev_ascii(ev_ascii[0]),
    .shift_o(shift_o[0]), .caps_o(caps_o[0]), .overrun(overrun[0])
  );

  ps2_scan_decoder #(.BREAK_OUT(1)) u_dec1 (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_vld(byte_vld),
    .ev_valid(ev_valid[1]), .ev_ready(ev_ready), .ev_code(ev_code[1]),
    .ev_ext(ev_ext[1]), .ev_break(ev_break[1]), .ev_ascii(ev_ascii[1]),
    .shift_o(shift_o[1]), .caps_o(caps_o[1]), .overrun(overrun[1])
  );

  always #5 clk = ~clk;

`ifdef PS2_DEC_CAPSLOCK_EN
  localparam bit CAPS_EN = 1'b1;
`else
  localparam bit CAPS_EN = 1'b0;
`endif

  localparam logic [7:0] LET_CODES [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG_CODES [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] DIG_SHIFT [10] = '{
    8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
  localparam logic [7:0] SPC_CODES [4] = '{8'h29, 8'h5A, 8'h66, 8'h75};
  localparam logic [7:0] CTRL_CODES [5] = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
  localparam logic [7:0] MOD_CODES [3] = '{8'h12, 8'h59, 8'h58};

  // Reference state: the raw prefix bytes seen so far plus the expected outputs.
  logic [7:0] pre [$];
  bit         m_ls, m_rs, m_caps, m_held;
  bit         m_vld [2];
  bit         m_ext [2];
  bit         m_brk [2];
  bit         m_ovr [2];
  logic [7:0] m_code [2];
  logic [7:0] m_ascii [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] xlate(input logic [7:0] c, input bit ext,
                                       input bit sh, input bit cp);
    if (ext) return 8'h00;
    for (int k = 0; k < 26; k++)
      if (LET_CODES[k] == c) return (sh ^ cp) ? 8'(8'h41 + k) : 8'(8'h61 + k);
    for (int k = 0; k < 10; k++)
      if (DIG_CODES[k] == c) return sh ? DIG_SHIFT[k] : 8'(8'h30 + k);
    case (c)
      8'h29:   return 8'h20;
      8'h5A:   return 8'h0D;
      8'h66:   return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    pre.delete();
    m_ls = 0; m_rs = 0; m_caps = 0; m_held = 0;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 0; m_ext[i] = 0; m_brk[i] = 0; m_ovr[i] = 0;
      m_code[i] = 8'h00; m_ascii[i] = 8'h00;
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit r);
    bit         done = 0;
    bit         ext  = 0;
    bit         brk  = 0;
    bit         gen;
    int         last = -1;
    logic [7:0] asc  = 8'h00;
    if (v) begin
      if (b == 8'hE0 || b == 8'hF0) begin
        pre.push_back(b);
      end else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF}) begin
        pre.delete();
      end else begin
        done = 1;
        // A later E0 restarts the prefix; only F0s after the last E0 count.
        foreach (pre[k]) if (pre[k] == 8'hE0) last = k;
        ext = (last >= 0);
        foreach (pre[k]) if (k > last && pre[k] == 8'hF0) brk = 1;
        pre.delete();
        asc = xlate(b, ext, m_ls | m_rs, m_caps);
      end
    end
    for (int i = 0; i < 2; i++) begin
      gen = done && (!brk || i == 1);
      m_ovr[i] = 0;
      if (gen && (!m_vld[i] || r)) begin
        m_vld[i] = 1; m_code[i] = b; m_ext[i] = ext; m_brk[i] = brk; m_ascii[i] = asc;
      end else if (gen) begin
        m_ovr[i] = 1;
      end else if (r) begin
        m_vld[i] = 0;
      end
    end
    if (done && !ext) begin
      if (b == 8'h12) m_ls = !brk;
      if (b == 8'h59) m_rs = !brk;
      if (CAPS_EN && b == 8'h58) begin
        if (brk) m_held = 0;
        else begin
          if (!m_held) m_caps = !m_caps;
          m_held = 1;
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), 8'(ev_valid[i]), 8'(m_vld[i]));
      chk($sformatf("overrun%0d", i), 8'(overrun[i]), 8'(m_ovr[i]));
      chk($sformatf("shift%0d", i), 8'(shift_o[i]), 8'(m_ls | m_rs));
      chk($sformatf("caps%0d", i), 8'(caps_o[i]), 8'(m_caps));
      if (m_vld[i]) begin
        chk($sformatf("code%0d", i), ev_code[i], m_code[i]);
        chk($sformatf("ext%0d", i), 8'(ev_ext[i]), 8'(m_ext[i]));
        chk($sformatf("break%0d", i), 8'(ev_break[i]), 8'(m_brk[i]));
        chk($sformatf("ascii%0d", i), ev_ascii[i], m_ascii[i]);
      end
    end
  endtask

  task automatic reset_chk();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid%0d", i), 8'(ev_valid[i]), 8'h00);
      chk($sformatf("rst_code%0d", i), ev_code[i], 8'h00);
      chk($sformatf("rst_ext%0d", i), 8'(ev_ext[i]), 8'h00);
      chk($sformatf("rst_break%0d", i), 8'(ev_break[i]), 8'h00);
      chk($sformatf("rst_ascii%0d", i), ev_ascii[i], 8'h00);
      chk($sformatf("rst_shift%0d", i), 8'(shift_o[i]), 8'h00);
      chk($sformatf("rst_caps%0d", i), 8'(caps_o[i]), 8'h00);
      chk($sformatf("rst_overrun%0d", i), 8'(overrun[i]), 8'h00);
    end
  endtask

  // Called #1 after an edge: drive, take the next edge, then check.
  task automatic step(input bit v, input logic [7:0] b, input bit r);
    byte_vld = v;
    byte_in  = b;
    ev_ready = r;
    @(posedge clk);
    model_step(v, b, r);
    #1;
    compare();
  endtask

  function automatic logic [7:0] rand_byte();
    int p = $urandom_range(0, 99);
    int k;
    if (p < 15) return 8'hE0;
    if (p < 30) return 8'hF0;
    if (p < 34) return CTRL_CODES[$urandom_range(0, 4)];
    if (p < 46) return MOD_CODES[$urandom_range(0, 2)];
    if (p < 92) begin
      k = $urandom_range(0, 39);
      if (k < 26) return LET_CODES[k];
      if (k < 36) return DIG_CODES[k - 26];
      return SPC_CODES[k - 36];
    end
    return 8'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0; byte_vld = 1'b0; byte_in = 8'h00; ev_ready = 1'b0;
    model_reset();
    #2;
    reset_chk();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single key, press then release.
    step(1, 8'h1C, 1);
    chk("single_code", ev_code[0], 8'h1C);
    chk("single_ascii", ev_ascii[0], 8'h61);
    chk("single_break", 8'(ev_break[0]), 8'h00);
    step(1, 8'hF0, 1);
    step(1, 8'h1C, 1);
    chk("single_no_break_ev", 8'(ev_valid[0]), 8'h00);
    chk("break_out_ev", 8'(ev_break[1]), 8'h01);
    step(0, 8'h00, 1);

    // Shifted letter.
    step(1, 8'h12, 1);
    chk("shift_on", 8'(shift_o[0]), 8'h01);
    step(1, 8'h1C, 1);
    chk("shift_ascii", ev_ascii[0], 8'h41);
    step(1, 8'hF0, 1); step(1, 8'h1C, 1); step(1, 8'hF0, 1);
    chk("shift_still_on", 8'(shift_o[0]), 8'h01);
    step(1, 8'h12, 1);
    chk("shift_off", 8'(shift_o[0]), 8'h00);

    // Extended key press and release.
    step(1, 8'hE0, 1); step(1, 8'h75, 1);
    chk("ext_make_ext", 8'(ev_ext[1]), 8'h01);
    chk("ext_make_code", ev_code[1], 8'h75);
    chk("ext_make_ascii", ev_ascii[1], 8'h00);
    step(1, 8'hE0, 1); step(1, 8'hF0, 1); step(1, 8'h75, 1);
    chk("ext_brk_ext", 8'(ev_ext[1]), 8'h01);
    chk("ext_brk_break", 8'(ev_break[1]), 8'h01);
    step(0, 8'h00, 1);

    // Backpressure: second make is dropped, first held.
    step(1, 8'h1C, 0);
    step(1, 8'h32, 0);
    chk("bp_overrun", 8'(overrun[0]), 8'h01);
    chk("bp_hold_code", ev_code[0], 8'h1C);
    step(1, 8'hFA, 0);
    chk("bp_ctrl_no_overrun", 8'(overrun[0]), 8'h00);
    step(0, 8'h00, 1);
    chk("bp_drained", 8'(ev_valid[0]), 8'h00);

`ifdef PS2_DEC_CAPSLOCK_EN
    step(1, 8'h58, 1); step(1, 8'h58, 1); step(1, 8'h58, 1);
    step(1, 8'hF0, 1); step(1, 8'h58, 1);
    chk("caps_once", 8'(caps_o[0]), 8'h01);
    step(1, 8'h1C, 1);
    chk("caps_upper", ev_ascii[0], 8'h41);
    step(1, 8'h12, 1); step(1, 8'h1C, 1);
    chk("caps_shift_lower", ev_ascii[0], 8'h61);
    step(1, 8'hF0, 1); step(1, 8'h12, 1);
`else
    step(1, 8'h58, 1);
    chk("caps_plain_ev", 8'(ev_valid[0]), 8'h01);
    chk("caps_plain_ascii", ev_ascii[0], 8'h00);
    chk("caps_plain_flag", 8'(caps_o[0]), 8'h00);
`endif

    // Reset with a pending E0 prefix.
    step(1, 8'hE0, 1);
    byte_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_chk();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 8'h1C, 1);
    chk("rst_mid_valid", 8'(ev_valid[0]), 8'h01);
    chk("rst_mid_ext", 8'(ev_ext[0]), 8'h00);

    for (int n = 0; n < 3000; n++)
      step(($urandom_range(0, 9) < 7), rand_byte(), ($urandom_range(0, 1) == 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
